my_cpu_core: RTL and testbench
==============================

Name: my_cpu_core

Overview:
Parametrised successor to the fixed 8-bit CPU top. It is a single-issue accumulator/register CPU with configurable data and address width and an internal clock-enable divider, so there is no derived clock. It adds zero flag, conditional jumps, HALT, and valid/ready handshakes on the input and output ports. Program memory is external and combinational (ROM-style): rom_addr drives rom_data in the same cycle.

Parameters:
DATA_W, 8, datapath/register/immediate width (>=4)
ADDR_W, 8, program-counter and rom_addr width (<=DATA_W)
CLK_DIV, 10, execute one instruction step every CLK_DIV clocks (1 = every clock)

Ports:
clock  in  1  system clock
nReset  in  1  asynchronous reset, active-low
rom_addr  out  ADDR_W  program counter
rom_data  in  8+DATA_W  instruction: [DATA_W+7:DATA_W]=opcode, [DATA_W-1:0]=imm
in_data  in  DATA_W  input-port data
in_valid  in  1  in_data is valid
in_ready  out  1  core accepts in_data this clock
out_data  out  DATA_W  output-port register
out_valid  out  1  out_data holds an unconsumed value
out_ready  in  1  consumer accepts out_data
halted  out  1  core has executed HALT

Behaviour:
- Reset (async, nReset=0): registers R0..R3=0, PC=0, C=0, Z=0, out_data=0, out_valid=0, halted=0, divider count=0.
- Tick: internal pulse on one clock of every CLK_DIV clocks. The first tick is at the CLK_DIV-th clock after reset release. All architectural state changes only on tick. Exception: an out_valid/out_ready handshake clears out_valid on any clock.
- Opcode fields: op[7:4]=class, op[3:2]=rd, op[1:0]=rs.
- Instruction classes (flags unchanged unless stated):
  - 0 MOV: rd=rs.
  - 1 MOVI: rd=imm.
  - 2 ADD: rd=rd+rs. C=carry-out, Z=(result==0).
  - 3 ADDI: rd=rd+imm. C and Z as ADD.
  - 4 SUB: rd=rd-rs. C=borrow (rd<rs unsigned), Z=(result==0).
  - 5 AND, 6 OR, 7 XOR: rd=rd op rs. C=0, Z=(result==0).
  - 8 IN: rd=in_data.
  - 9 OUT: out_data=rs, out_valid=1.
  - A JMP, B JC (if C), C JZ (if Z), D JNC (if !C): PC=imm[ADDR_W-1:0] when taken.
  - E NOP.
  - F HALT: halted=1.
- PC: increments by 1 per completed instruction unless a jump is taken. It wraps from 2^ADDR_W-1 to 0.
- Arithmetic is DATA_W bits, unsigned. The carry is bit DATA_W of the (DATA_W+1)-bit sum/difference.
- IN handshake: in_ready=tick & class==8 & !halted.
  - Completes only if in_valid on that clock.
  - Otherwise it is a stall: PC, registers and flags hold, and the instruction retries at the next tick.
- OUT handshake: OUT completes on a tick if out_valid==0 or out_ready==1 on that clock. Otherwise it stalls as above.
  - Simultaneous consume and OUT: out_data takes the new value and out_valid stays 1.
  - Consume without OUT: out_valid=0 next clock.
- halted=1: no further state change except out_valid clearing via handshake. in_ready=0. Only reset exits.
- Read-before-write: rd==rs is legal. The source is sampled before the update.
- Reset mid-stall or mid-handshake: all state returns to reset values immediately. No pending transfer survives.

Decomposition:
- Package my8cpu_pkg: opcode class constants (OP_MOV..OP_HALT), field positions of rd/rs/opcode.
- Sub-module clock_enable_div: parameter CLK_DIV, ports clock, nReset, tick. It replaces the old output-clock divider with a single-clock enable pulse.
- ALU stays inline (a case on class).

Test Plan:
- Reset/tick: CLK_DIV=10, program NOP×3. rom_addr=0 during reset and goes 0→1→2 on clocks 10, 20, 30 after release. All outputs 0 throughout.
- Arithmetic/flags, DATA_W=8:
  - MOVI R0,0xFF; ADDI R0,0x01 → R0=0x00, C=1, Z=1.
  - Then JC 0x10 → rom_addr=0x10.
  - SUB R1(=3),R2(=5) → R1=0xFE, C=1, Z=0.
- Input stall: IN R1 with in_valid=0 for 3 ticks → PC held, in_ready pulses each tick. Then in_valid=1, in_data=0x5A → R1=0x5A, PC+1.
- Output backpressure: OUT R0 (0x11), then OUT R1 (0x22) with out_ready=0 → second OUT stalls, out_data=0x11. Raise out_ready on a tick → out_data=0x22, out_valid stays 1.
- Wrap/HALT, ADDR_W=4, CLK_DIV=1:
  - NOP at all 16 addresses → rom_addr wraps 15→0.
  - Then HALT → halted=1, rom_addr frozen; async reset mid-run → all outputs 0 at once.
- Width generality: DATA_W=12, ADDR_W=6. ADDI R3,0xFFF from 1 → R3=0x000, C=1. JMP 0xFC5 → rom_addr=0x05.

Source files
------------

// File: rtl/my8cpu_pkg.sv
// Shared opcode encoding for the my_cpu_core accumulator/register CPU.
package my8cpu_pkg;

  // Opcode byte width; the instruction word is {opcode, imm}.
  localparam int unsigned OPC_W  = 8;
  // Field positions inside the opcode byte.
  localparam int unsigned CLS_LSB = 4;
  localparam int unsigned RD_LSB  = 2;
  localparam int unsigned RS_LSB  = 0;

  typedef enum logic [3:0] {
    OP_MOV  = 4'h0,
    OP_MOVI = 4'h1,
    OP_ADD  = 4'h2,
    OP_ADDI = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_IN   = 4'h8,
    OP_OUT  = 4'h9,
    OP_JMP  = 4'hA,
    OP_JC   = 4'hB,
    OP_JZ   = 4'hC,
    OP_JNC  = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } op_class_e;

  // Decoded opcode byte: class in [7:4], rd in [3:2], rs in [1:0].
  typedef struct packed {
    op_class_e  cls;
    logic [1:0] rd;
    logic [1:0] rs;
  } opcode_t;

  // Split a raw opcode byte into its fields.
  function automatic opcode_t decode_op(input logic [OPC_W-1:0] raw);
    opcode_t d;
    d.cls = op_class_e'(raw[CLS_LSB +: 4]);
    d.rd  = raw[RD_LSB +: 2];
    d.rs  = raw[RS_LSB +: 2];
    return d;
  endfunction

endpackage

// File: rtl/clock_enable_div.sv
// Single-clock enable generator: tick is high for one clock out of every CLK_DIV.
module clock_enable_div #(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic clock,
  input  logic nReset,
  output logic tick
);

  if (CLK_DIV <= 1) begin : g_every
    // Every clock is a step, including the first one after reset release.
    always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) tick <= 1'b1;
      else         tick <= 1'b1;
    end
  end else begin : g_count
    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    logic [CNT_W-1:0] count;

    // Count clocks since reset; tick is registered one count ahead so it lands on the CLK_DIV-th clock.
    always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
        count <= '0;
        tick  <= 1'b0;
      end else begin
        count <= (count == CNT_W'(CLK_DIV - 1)) ? '0 : count + CNT_W'(1);
        tick  <= (count == CNT_W'(CLK_DIV - 2));
      end
    end
  end

endmodule

// File: rtl/my_cpu_core.sv
// Parametrised single-issue register CPU with external combinational ROM and valid/ready I/O ports.
module my_cpu_core
  import my8cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned CLK_DIV = 10
) (
  input  logic                    clock,
  input  logic                    nReset,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [OPC_W+DATA_W-1:0] rom_data,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    halted
);

  logic              tick;
  opcode_t           op;
  logic [DATA_W-1:0] imm;

  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              c_q, c_d, z_q, z_d;
  logic [DATA_W-1:0] out_data_d;
  logic              out_valid_d, halted_d;

  logic              exec_c;
  logic [DATA_W-1:0] src_c, dst_c, opnd_c, res_c;
  logic [DATA_W:0]   sum_c;
  logic              adv_c, jump_c;

  clock_enable_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clock  (clock),
    .nReset (nReset),
    .tick   (tick)
  );

  assign op       = decode_op(rom_data[OPC_W+DATA_W-1:DATA_W]);
  assign imm      = rom_data[DATA_W-1:0];
  assign rom_addr = pc_q;

  // An instruction step happens only on a tick while not halted.
  assign exec_c   = tick & ~halted;
  assign in_ready = exec_c & (op.cls == OP_IN);

  // Sources are read from the current register file, so rd==rs sees the old value.
  assign src_c  = regs_q[op.rs];
  assign dst_c  = regs_q[op.rd];
  assign opnd_c = (op.cls == OP_ADDI) ? imm : src_c;

  // One (DATA_W+1)-bit adder/subtractor; the top bit is carry or borrow.
  always_comb begin
    sum_c = '0;
    if (op.cls == OP_SUB) sum_c = {1'b0, dst_c} - {1'b0, src_c};
    else                  sum_c = {1'b0, dst_c} + {1'b0, opnd_c};
  end

  // Next architectural state; stalled IN/OUT leave PC, registers and flags untouched.
  always_comb begin
    regs_d      = regs_q;
    pc_d        = pc_q;
    c_d         = c_q;
    z_d         = z_q;
    out_data_d  = out_data;
    out_valid_d = out_valid & ~out_ready;
    halted_d    = halted;
    res_c       = '0;
    adv_c       = 1'b0;
    jump_c      = 1'b0;

    if (exec_c) begin
      adv_c = 1'b1;
      case (op.cls)
        OP_MOV:  regs_d[op.rd] = src_c;
        OP_MOVI: regs_d[op.rd] = imm;
        OP_ADD, OP_ADDI, OP_SUB: begin
          regs_d[op.rd] = sum_c[DATA_W-1:0];
          c_d           = sum_c[DATA_W];
          z_d           = (sum_c[DATA_W-1:0] == '0);
        end
        OP_AND, OP_OR, OP_XOR: begin
          if (op.cls == OP_AND)     res_c = dst_c & src_c;
          else if (op.cls == OP_OR) res_c = dst_c | src_c;
          else                      res_c = dst_c ^ src_c;
          regs_d[op.rd] = res_c;
          c_d           = 1'b0;
          z_d           = (res_c == '0);
        end
        OP_IN: begin
          if (in_valid) regs_d[op.rd] = in_data;
          else          adv_c = 1'b0;
        end
        OP_OUT: begin
          if (!out_valid || out_ready) begin
            out_data_d  = src_c;
            out_valid_d = 1'b1;
          end else begin
            adv_c = 1'b0;
          end
        end
        OP_JMP: jump_c = 1'b1;
        OP_JC:  jump_c = c_q;
        OP_JZ:  jump_c = z_q;
        OP_JNC: jump_c = ~c_q;
        // HALT freezes the PC on the HALT instruction itself.
        OP_HALT: begin
          halted_d = 1'b1;
          adv_c    = 1'b0;
        end
        default: ;
      endcase

      if (jump_c)     pc_d = imm[ADDR_W-1:0];
      else if (adv_c) pc_d = pc_q + ADDR_W'(1);
    end
  end

  // Architectural state registers.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      pc_q      <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
      pc_q      <= pc_d;
      c_q       <= c_d;
      z_q       <= z_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      halted    <= halted_d;
    end
  end

endmodule

// File: tb/tb_my_cpu_core.sv
// Bench for my_cpu_core: directed scenarios plus random programs against an instruction-level model.
module tb_my_cpu_core;

  logic clock = 1'b0;
  logic nReset = 1'b0;
  always #5 clock = ~clock;

  // Instance A: DATA_W=8, ADDR_W=8, CLK_DIV=10
  logic [7:0]  rom_addr_a;
  logic [15:0] rom_data_a;
  logic [7:0]  id_a, out_data_a;
  logic        iv_a, in_ready_a, out_valid_a, or_a, halted_a;
  logic [15:0] rom_a [256];
  assign rom_data_a = rom_a[rom_addr_a];

  // Instance B: DATA_W=12, ADDR_W=4, CLK_DIV=1
  logic [3:0]  rom_addr_b;
  logic [19:0] rom_data_b;
  logic [11:0] id_b, out_data_b;
  logic        iv_b, in_ready_b, out_valid_b, or_b, halted_b;
  logic [19:0] rom_b [16];
  assign rom_data_b = rom_b[rom_addr_b];

  my_cpu_core #(.DATA_W(8), .ADDR_W(8), .CLK_DIV(10)) dut_a (
    .clock(clock), .nReset(nReset), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .in_data(id_a), .in_valid(iv_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(or_a), .halted(halted_a)
  );

  my_cpu_core #(.DATA_W(12), .ADDR_W(4), .CLK_DIV(1)) dut_b (
    .clock(clock), .nReset(nReset), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .in_data(id_b), .in_valid(iv_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(or_b), .halted(halted_b)
  );

  // Instruction-level model state
  typedef struct packed {
    logic [3:0][31:0] r;
    logic [31:0]      pc;
    logic             c, z;
    logic [31:0]      od;
    logic             ov, h;
    logic [31:0]      cyc;
  } ms_t;

  ms_t  ma, mb;
  logic ir_a_act, ir_a_exp, ir_b_act, ir_b_exp;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic bit is_tick(input ms_t s, input int div);
    return (int'(s.cyc) % div) == (div - 1);
  endfunction

  function automatic bit exp_in_ready(input ms_t s, input int dw, input int div, input logic [31:0] instr);
    int unsigned cls;
    cls = ((instr >> dw) >> 4) & 32'hF;
    return is_tick(s, div) && !s.h && (cls == 8);
  endfunction

  // One clock of the architectural model: executes an instruction on ticks.
  function automatic ms_t mstep(input ms_t s, input int dw, input int aw, input int div,
                                input logic [31:0] instr, input logic iv,
                                input logic [31:0] idata, input logic ordy);
    ms_t n;
    int unsigned dm, am, op, imm, cls, rd, rs, a, b, res;
    bit adv, jmp;
    dm = (32'd1 << dw) - 1;
    am = (32'd1 << aw) - 1;
    n = s;
    n.cyc = s.cyc + 1;
    if (s.ov && ordy) n.ov = 1'b0;
    if (is_tick(s, div) && !s.h) begin
      op  = (instr >> dw) & 32'hFF;
      imm = instr & dm;
      cls = op >> 4;
      rd  = (op >> 2) & 3;
      rs  = op & 3;
      a   = s.r[rd];
      b   = s.r[rs];
      adv = 1;
      jmp = 0;
      case (cls)
        0: n.r[rd] = b;
        1: n.r[rd] = imm;
        2, 3: begin
          res = a + ((cls == 2) ? b : imm);
          n.r[rd] = res & dm;
          n.c = (res > dm);
          n.z = ((res & dm) == 0);
        end
        4: begin
          n.r[rd] = (a - b) & dm;
          n.c = (a < b);
          n.z = (a == b);
        end
        5, 6, 7: begin
          res = (cls == 5) ? (a & b) : (cls == 6) ? (a | b) : (a ^ b);
          n.r[rd] = res;
          n.c = 1'b0;
          n.z = (res == 0);
        end
        8: if (iv) n.r[rd] = idata & dm; else adv = 0;
        9: if (!s.ov || ordy) begin n.od = b; n.ov = 1'b1; end else adv = 0;
        10: jmp = 1;
        11: jmp = s.c;
        12: jmp = s.z;
        13: jmp = !s.c;
        15: begin n.h = 1'b1; adv = 0; end
        default: ;
      endcase
      if (jmp)      n.pc = imm & am;
      else if (adv) n.pc = (s.pc + 1) & am;
    end
    return n;
  endfunction

  // Advance one clock: sample in_ready mid-cycle, step both models, land at posedge+1.
  task automatic step();
    ms_t na, nb;
    @(negedge clock);
    #1;
    ir_a_act = in_ready_a;
    ir_a_exp = exp_in_ready(ma, 8, 10, 32'(rom_a[ma.pc[7:0]]));
    ir_b_act = in_ready_b;
    ir_b_exp = exp_in_ready(mb, 12, 1, 32'(rom_b[mb.pc[3:0]]));
    na = mstep(ma, 8, 8, 10, 32'(rom_a[ma.pc[7:0]]), iv_a, 32'(id_a), or_a);
    nb = mstep(mb, 12, 4, 1, 32'(rom_b[mb.pc[3:0]]), iv_b, 32'(id_b), or_b);
    @(posedge clock);
    #1;
    ma = na;
    mb = nb;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    ma = '0;
    mb = '0;
    repeat (2) @(posedge clock);
    #1;
    nReset = 1'b1;
  endtask

  task automatic load_nops();
    for (int i = 0; i < 256; i++) rom_a[i] = 16'hE000;
    for (int i = 0; i < 16; i++)  rom_b[i] = 20'hE0000;
  endtask

  task automatic test_reset();
    load_nops();
    nReset = 1'b0;
    ma = '0;
    mb = '0;
    #2;
    n_checks++; if (rom_addr_a !== 8'h00) $display("FAIL reset_rom_addr got=%h exp=00", rom_addr_a); else n_pass++;
    n_checks++; if (out_valid_a !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid_a); else n_pass++;
    n_checks++; if (out_data_a !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", out_data_a); else n_pass++;
    n_checks++; if (halted_a !== 1'b0) $display("FAIL reset_halted got=%b exp=0", halted_a); else n_pass++;
    n_checks++; if (in_ready_a !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready_a); else n_pass++;
    repeat (2) @(posedge clock);
    #1;
    nReset = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      n_checks++;
      if (rom_addr_a !== 8'(k / 10)) $display("FAIL tick_rom_addr clk=%0d got=%h exp=%h", k, rom_addr_a, 8'(k / 10));
      else n_pass++;
      n_checks++;
      if ({out_valid_a, out_data_a, halted_a, ir_a_act} !== 11'd0)
        $display("FAIL tick_outputs clk=%0d got=%b exp=0", k, {out_valid_a, out_data_a, halted_a, ir_a_act});
      else n_pass++;
    end
  endtask

  task automatic test_arith();
    load_nops();
    rom_a[8'h00] = 16'h10FF;  // MOVI R0,FF
    rom_a[8'h01] = 16'h3001;  // ADDI R0,01
    rom_a[8'h02] = 16'hB010;  // JC 10
    rom_a[8'h10] = 16'hC018;  // JZ 18
    rom_a[8'h18] = 16'h9000;  // OUT R0
    rom_a[8'h19] = 16'h1403;  // MOVI R1,3
    rom_a[8'h1A] = 16'h1805;  // MOVI R2,5
    rom_a[8'h1B] = 16'h4600;  // SUB R1,R2
    rom_a[8'h1C] = 16'hB030;  // JC 30
    rom_a[8'h30] = 16'hC040;  // JZ 40 (not taken)
    rom_a[8'h31] = 16'h9100;  // OUT R1
    rom_a[8'h32] = 16'hF000;  // HALT
    or_a = 1'b1;
    do_reset();
    run(30);
    n_checks++; if (rom_addr_a !== 8'h10) $display("FAIL arith_jc_carry got=%h exp=10", rom_addr_a); else n_pass++;
    run(10);
    n_checks++; if (rom_addr_a !== 8'h18) $display("FAIL arith_jz_zero got=%h exp=18", rom_addr_a); else n_pass++;
    run(10);
    n_checks++; if ({out_valid_a, out_data_a} !== 9'h100) $display("FAIL arith_out_r0 got=%h exp=100", {out_valid_a, out_data_a}); else n_pass++;
    run(40);
    n_checks++; if (rom_addr_a !== 8'h30) $display("FAIL arith_sub_borrow got=%h exp=30", rom_addr_a); else n_pass++;
    run(10);
    n_checks++; if (rom_addr_a !== 8'h31) $display("FAIL arith_jz_not_taken got=%h exp=31", rom_addr_a); else n_pass++;
    run(10);
    n_checks++; if ({out_valid_a, out_data_a} !== 9'h1FE) $display("FAIL arith_sub_result got=%h exp=1FE", {out_valid_a, out_data_a}); else n_pass++;
    run(10);
    n_checks++; if ({halted_a, rom_addr_a} !== 9'h132) $display("FAIL arith_halt got=%h exp=132", {halted_a, rom_addr_a}); else n_pass++;
  endtask

  task automatic test_in_stall();
    int pulses;
    load_nops();
    rom_a[0] = 16'h8400;  // IN R1
    rom_a[1] = 16'h9100;  // OUT R1
    rom_a[2] = 16'hF000;
    iv_a = 1'b0;
    or_a = 1'b1;
    do_reset();
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (ir_a_act === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 3) $display("FAIL in_ready_pulses got=%0d exp=3", pulses); else n_pass++;
    n_checks++; if (rom_addr_a !== 8'h00) $display("FAIL in_stall_pc got=%h exp=00", rom_addr_a); else n_pass++;
    iv_a = 1'b1;
    id_a = 8'h5A;
    run(10);
    iv_a = 1'b0;
    n_checks++; if (rom_addr_a !== 8'h01) $display("FAIL in_accept_pc got=%h exp=01", rom_addr_a); else n_pass++;
    run(10);
    n_checks++; if ({out_valid_a, out_data_a} !== 9'h15A) $display("FAIL in_data_value got=%h exp=15A", {out_valid_a, out_data_a}); else n_pass++;
  endtask

  task automatic test_out_backpressure();
    load_nops();
    rom_a[0] = 16'h1011;  // MOVI R0,11
    rom_a[1] = 16'h1422;  // MOVI R1,22
    rom_a[2] = 16'h9000;  // OUT R0
    rom_a[3] = 16'h9100;  // OUT R1
    rom_a[4] = 16'hF000;
    or_a = 1'b0;
    do_reset();
    run(30);
    n_checks++; if ({out_valid_a, out_data_a, rom_addr_a} !== 17'h1_11_03) $display("FAIL out_first got=%h exp=11103", {out_valid_a, out_data_a, rom_addr_a}); else n_pass++;
    run(20);
    n_checks++; if ({out_valid_a, out_data_a, rom_addr_a} !== 17'h1_11_03) $display("FAIL out_stall got=%h exp=11103", {out_valid_a, out_data_a, rom_addr_a}); else n_pass++;
    run(9);
    or_a = 1'b1;
    run(1);
    n_checks++; if ({out_valid_a, out_data_a, rom_addr_a} !== 17'h1_22_04) $display("FAIL out_consume_and_write got=%h exp=12204", {out_valid_a, out_data_a, rom_addr_a}); else n_pass++;
    run(1);
    n_checks++; if (out_valid_a !== 1'b0) $display("FAIL out_consume_only got=%b exp=0", out_valid_a); else n_pass++;
  endtask

  task automatic test_wrap_halt();
    load_nops();
    do_reset();
    run(16);
    n_checks++; if (rom_addr_b !== 4'h0) $display("FAIL wrap_pc got=%h exp=0", rom_addr_b); else n_pass++;
    run(3);
    rom_b[3] = 20'hF0000;
    run(1);
    n_checks++; if ({halted_b, rom_addr_b} !== 5'h13) $display("FAIL halt_enter got=%h exp=13", {halted_b, rom_addr_b}); else n_pass++;
    run(5);
    n_checks++; if ({halted_b, rom_addr_b, ir_b_act} !== 6'b1_0011_0) $display("FAIL halt_frozen got=%b exp=100110", {halted_b, rom_addr_b, ir_b_act}); else n_pass++;
    nReset = 1'b0;
    ma = '0;
    mb = '0;
    #1;
    n_checks++;
    if ({halted_b, rom_addr_b, out_valid_b, out_data_b} !== 18'd0)
      $display("FAIL async_reset got=%h exp=0", {halted_b, rom_addr_b, out_valid_b, out_data_b});
    else n_pass++;
    rom_b[3] = 20'hE0000;
    do_reset();
  endtask

  task automatic test_width();
    load_nops();
    rom_b[0]  = 20'h1C_001;  // MOVI R3,1
    rom_b[1]  = 20'h3C_FFF;  // ADDI R3,FFF
    rom_b[2]  = 20'hB0_00A;  // JC A
    rom_b[10] = 20'hC0_00C;  // JZ C
    rom_b[12] = 20'h93_000;  // OUT R3
    rom_b[13] = 20'hA0_FC5;  // JMP FC5
    rom_b[5]  = 20'hF0_000;
    or_b = 1'b0;
    do_reset();
    run(3);
    n_checks++; if (rom_addr_b !== 4'hA) $display("FAIL width_carry got=%h exp=A", rom_addr_b); else n_pass++;
    run(1);
    n_checks++; if (rom_addr_b !== 4'hC) $display("FAIL width_zero got=%h exp=C", rom_addr_b); else n_pass++;
    run(1);
    n_checks++; if ({out_valid_b, out_data_b} !== 13'h1000) $display("FAIL width_result got=%h exp=1000", {out_valid_b, out_data_b}); else n_pass++;
    run(1);
    n_checks++; if (rom_addr_b !== 4'h5) $display("FAIL width_jmp_trunc got=%h exp=5", rom_addr_b); else n_pass++;
    run(1);
    n_checks++; if (halted_b !== 1'b1) $display("FAIL width_halt got=%b exp=1", halted_b); else n_pass++;
    or_b = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] opb;
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < 256; i++) begin
        opb = 8'($urandom);
        if (opb[7:4] == 4'hF && $urandom_range(0, 7) != 0) opb[7:4] = 4'hE;
        rom_a[i] = {opb, 8'($urandom)};
      end
      for (int i = 0; i < 16; i++) begin
        opb = 8'($urandom);
        if (opb[7:4] == 4'hF && $urandom_range(0, 7) != 0) opb[7:4] = 4'hE;
        rom_b[i] = {opb, 12'($urandom)};
      end
      do_reset();
      for (int k = 0; k < 600; k++) begin
        iv_a = 1'($urandom); id_a = 8'($urandom);  or_a = 1'($urandom);
        iv_b = 1'($urandom); id_b = 12'($urandom); or_b = 1'($urandom);
        step();
        n_checks++;
        if ({rom_addr_a, out_data_a, out_valid_a, halted_a, ir_a_act} !== {ma.pc[7:0], ma.od[7:0], ma.ov, ma.h, ir_a_exp})
          $display("FAIL rand_a clk=%0d got=%h exp=%h", k, {rom_addr_a, out_data_a, out_valid_a, halted_a, ir_a_act},
                   {ma.pc[7:0], ma.od[7:0], ma.ov, ma.h, ir_a_exp});
        else n_pass++;
        n_checks++;
        if ({rom_addr_b, out_data_b, out_valid_b, halted_b, ir_b_act} !== {mb.pc[3:0], mb.od[11:0], mb.ov, mb.h, ir_b_exp})
          $display("FAIL rand_b clk=%0d got=%h exp=%h", k, {rom_addr_b, out_data_b, out_valid_b, halted_b, ir_b_act},
                   {mb.pc[3:0], mb.od[11:0], mb.ov, mb.h, ir_b_exp});
        else n_pass++;
      end
    end
    iv_a = 1'b0; or_a = 1'b1; iv_b = 1'b0; or_b = 1'b1;
  endtask

  initial begin
    iv_a = 1'b0; id_a = '0; or_a = 1'b1;
    iv_b = 1'b0; id_b = '0; or_b = 1'b1;
    ma = '0;
    mb = '0;
    ir_a_act = 1'b0; ir_a_exp = 1'b0; ir_b_act = 1'b0; ir_b_exp = 1'b0;
    test_reset();
    test_arith();
    test_in_stall();
    test_out_backpressure();
    test_wrap_halt();
    test_width();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
